// File: rtl/edge_value_accumulator.sv
// Border-pixel accumulator for 8x8 blocks: turns sequencer offsets into pixel-RAM addresses and sums the 28 samples.
// Optional averaging divider is built when EDGE_VALUE_AVG_EN is defined.
module edge_value_accumulator #(
    parameter int IMG_WIDTH  = 320,
    parameter int ADDR_W     = 17,
    parameter int PIX_W      = 8,
    parameter int EDGE_COUNT = 28,
    localparam int OFF_W     = $clog2(7 * IMG_WIDTH + 8),
    localparam int SUM_W     = PIX_W + 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] block_base_addr,
    input  logic              ld_read_address,
    input  logic              ld_edge_value,
    input  logic [OFF_W-1:0]  rel_offset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  edge_sum,
    output logic [PIX_W-1:0]  edge_avg,
    output logic [4:0]        sample_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, DIVIDE, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base_q;
    logic              pend;

`ifdef EDGE_VALUE_AVG_EN
    localparam int REM_W = $clog2(EDGE_COUNT);
    localparam int CNT_W = $clog2(SUM_W);

    logic [REM_W-1:0] rem;
    logic [PIX_W-1:0] quot;
    logic [CNT_W-1:0] div_cnt;
    logic             div_bit;
    logic [REM_W:0]   step;

    // One restoring-division step: returns {quotient bit, new remainder}.
    function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] r, input logic b);
        logic [REM_W:0] trial;
        trial = {r, b};
        if (trial >= (REM_W+1)'(EDGE_COUNT))
            return {1'b1, REM_W'(trial - (REM_W+1)'(EDGE_COUNT))};
        return {1'b0, trial[REM_W-1:0]};
    endfunction

    // Dividend bits are taken MSB first straight from the frozen sum.
    assign div_bit  = edge_sum[CNT_W'(SUM_W-1) - div_cnt];
    assign step     = div_step(rem, div_bit);
    assign edge_avg = quot;
`else
    assign edge_avg = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            base_q       <= '0;
            mem_addr     <= '0;
            pend         <= 1'b0;
            edge_sum     <= '0;
            sample_count <= '0;
`ifdef EDGE_VALUE_AVG_EN
            rem          <= '0;
            quot         <= '0;
            div_cnt      <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q       <= block_base_addr;
                        edge_sum     <= '0;
                        sample_count <= '0;
                        pend         <= 1'b0;
`ifdef EDGE_VALUE_AVG_EN
                        rem          <= '0;
                        quot         <= '0;
                        div_cnt      <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (ld_read_address)
                        mem_addr <= base_q + ADDR_W'(rel_offset);
                    // RAM data for the flagged read arrives one cycle after the flag.
                    pend <= ld_edge_value;
                    if (pend) begin
                        edge_sum     <= edge_sum + SUM_W'(mem_rdata);
                        sample_count <= sample_count + 5'd1;
                    end
                end
`ifdef EDGE_VALUE_AVG_EN
                DIVIDE: begin
                    rem     <= step[REM_W-1:0];
                    quot    <= {quot[PIX_W-2:0], step[REM_W]};
                    div_cnt <= div_cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_n = COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                if (pend && sample_count == 5'(EDGE_COUNT - 1))
`ifdef EDGE_VALUE_AVG_EN
                    state_n = DIVIDE;
`else
                    state_n = DONE;
`endif
            end
`ifdef EDGE_VALUE_AVG_EN
            DIVIDE: begin
                busy = 1'b1;
                if (div_cnt == CNT_W'(SUM_W - 1))
                    state_n = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_edge_value_accumulator.sv
// Bench for edge_value_accumulator: directed test-plan blocks plus random blocks against a pixel-sum model.
// Expectations follow EDGE_VALUE_AVG_EN the same way the design build does.
module tb_edge_value_accumulator;

    localparam int ADDR_W = 17;
    localparam int PIX_W  = 8;
    localparam int N      = 28;
`ifdef EDGE_VALUE_AVG_EN
    localparam int DIV_LAT = 13;
    localparam bit AVG     = 1'b1;
`else
    localparam int DIV_LAT = 0;
    localparam bit AVG     = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] block_base_addr;
    logic              ld_read_address;
    logic              ld_edge_value;
    logic [11:0]       rel_offset;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata = '0;
    logic              busy;
    logic              done;
    logic [PIX_W+4:0]  edge_sum;
    logic [PIX_W-1:0]  edge_avg;
    logic [4:0]        sample_count;

    edge_value_accumulator dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .block_base_addr (block_base_addr),
        .ld_read_address (ld_read_address),
        .ld_edge_value   (ld_edge_value),
        .rel_offset      (rel_offset),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .done            (done),
        .edge_sum        (edge_sum),
        .edge_avg        (edge_avg),
        .sample_count    (sample_count)
    );

    always #5 clock = ~clock;

    // Synchronous pixel RAM: data for an address appears one edge later.
    bit [7:0] ram [0:131071];
    always @(posedge clock) mem_rdata <= ram[mem_addr];

    int offs [N];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int addr_of(input int base, input int k);
        return (base + offs[k]) % 131072;
    endfunction

    // mode 0: constant val, 1: alternating 0/1 in sequencer order, 2: random.
    task automatic fill(input int base, input int mode, input int val);
        int p;
        exp_sum = 0;
        for (int k = 0; k < N; k++) begin
            p = (mode == 0) ? val : (mode == 1) ? (k % 2) : int'($urandom_range(0, 255));
            ram[addr_of(base, k)] = 8'(p);
            exp_sum += p;
        end
    endtask

    task automatic run_block(input int base, input int restart_at, input int reset_at, input string tag);
        int exp_avg;
        exp_avg = AVG ? exp_sum / N : 0;
        start = 1'b1;
        block_base_addr = 17'(base);
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k <= N; k++) begin
            ld_read_address = (k < N);
            rel_offset      = (k < N) ? 12'(offs[k]) : 12'd0;
            ld_edge_value   = (k > 0);
            start           = (k == restart_at);
            if (k == restart_at) block_base_addr = 17'(base) ^ 17'h155;
            reset           = (k == reset_at);
            @(posedge clock); #1;
            start = 1'b0;
            if (k == reset_at) begin
                reset = 1'b0;
                ld_read_address = 1'b0;
                ld_edge_value = 1'b0;
                chk({tag, "_rst_busy"}, 32'(busy), 0);
                chk({tag, "_rst_sum"}, 32'(edge_sum), 0);
                chk({tag, "_rst_cnt"}, 32'(sample_count), 0);
                chk({tag, "_rst_addr"}, 32'(mem_addr), 0);
                chk({tag, "_rst_done"}, 32'(done), 0);
                return;
            end
            if (k < N) chk({tag, "_addr"}, 32'(mem_addr), 32'(addr_of(base, k)));
            chk({tag, "_cnt"}, 32'(sample_count), (k >= 2) ? 32'(k - 1) : 32'd0);
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_done_early"}, 32'(done), 0);
        end
        ld_read_address = 1'b0;
        ld_edge_value   = 1'b0;
        for (int i = 0; i <= DIV_LAT; i++) begin
            @(posedge clock); #1;
            if (i == 0) begin
                chk({tag, "_cnt28"}, 32'(sample_count), N);
                chk({tag, "_sum"}, 32'(edge_sum), 32'(exp_sum));
            end
            chk({tag, "_done"}, 32'(done), (i == DIV_LAT) ? 32'd1 : 32'd0);
            chk({tag, "_busy_tail"}, 32'(busy), (i < DIV_LAT) ? 32'd1 : 32'd0);
        end
        chk({tag, "_avg"}, 32'(edge_avg), 32'(exp_avg));
        // Outside COLLECT the strobes must have no effect; results hold.
        ld_read_address = 1'b1;
        ld_edge_value   = 1'b1;
        rel_offset      = 12'd5;
        @(posedge clock); #1;
        ld_read_address = 1'b0;
        ld_edge_value   = 1'b0;
        chk({tag, "_done_once"}, 32'(done), 0);
        chk({tag, "_busy_idle"}, 32'(busy), 0);
        chk({tag, "_addr_hold"}, 32'(mem_addr), 32'(addr_of(base, N - 1)));
        chk({tag, "_sum_hold"}, 32'(edge_sum), 32'(exp_sum));
        chk({tag, "_avg_hold"}, 32'(edge_avg), 32'(exp_avg));
        chk({tag, "_cnt_hold"}, 32'(sample_count), N);
    endtask

    initial begin
        int idx;
        int b;
        idx = 0;
        for (int c = 0; c < 8; c++) begin offs[idx] = c; idx++; end
        for (int r = 1; r < 7; r++) begin
            offs[idx] = r * 320;     idx++;
            offs[idx] = r * 320 + 7; idx++;
        end
        for (int c = 0; c < 8; c++) begin offs[idx] = 2240 + c; idx++; end

        reset = 1'b1;
        start = 1'b0;
        block_base_addr = '0;
        ld_read_address = 1'b0;
        ld_edge_value = 1'b0;
        rel_offset = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_addr", 32'(mem_addr), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_sum", 32'(edge_sum), 0);
        chk("reset_avg", 32'(edge_avg), 0);
        chk("reset_cnt", 32'(sample_count), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        fill(0, 0, 10);       run_block(0, -1, -1, "tens_base0");
        fill(1000, 0, 255);   run_block(1000, -1, -1, "max_base1000");
        fill(76799, 1, 0);    run_block(76799, -1, -1, "alt_wrap");
        b = int'($urandom_range(0, 131071));
        fill(b, 2, 0);        run_block(b, 12, -1, "restart12");
        b = int'($urandom_range(0, 131071));
        fill(b, 2, 0);        run_block(b, -1, 20, "reset20");
        fill(b, 2, 0);        run_block(b, -1, -1, "after_reset");
        b = int'($urandom_range(0, 131071));
        fill(b, 0, 100);      run_block(b, -1, -1, "hundreds");
        for (int t = 0; t < 3; t++) begin
            b = int'($urandom_range(0, 131071));
            fill(b, 2, 0);    run_block(b, -1, -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
